// File: rtl/button_event_arbiter.sv
// button_event_arbiter
//   Queues one pending event per button from one-cycle press pulses and
//   hands them out one at a time, round-robin, on a valid/ready channel.
//
// Ports
//   clk       in          system clock, rising edge
//   rstb      in          asynchronous active-low reset
//   pulse_in  in  [N-1:0] one-cycle press pulses, bit i = button i
//   ev_valid  out         event present on ev_id
//   ev_id     out [ID_W]  index of the granted button
//   ev_ready  in          consumer accepts when ev_valid && ev_ready
//   pending   out [N-1:0] registered per-button pending flags
//   drop_cnt  out [7:0]   saturating dropped-press count
//                         (only when BTN_ARB_DROP_CNT_EN is defined)
//
// FSM states
//   state     | meaning
//   S_IDLE    | no event presented; load a winner as soon as one is pending
//   S_PRESENT | event held on ev_id until the consumer takes it
module button_event_arbiter #(
   parameter int N    = 4,
   parameter int ID_W = 2
) (
   input  logic            clk,
   input  logic            rstb,
   input  logic [N-1:0]    pulse_in,
   output logic            ev_valid,
   output logic [ID_W-1:0] ev_id,
   input  logic            ev_ready,
   output logic [N-1:0]    pending
`ifdef BTN_ARB_DROP_CNT_EN
   ,
   output logic [7:0]      drop_cnt
`endif
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_PRESENT = 2'd1
   } state_t;

   state_t            state_q, state_d;
   logic              ev_valid_q, ev_valid_d;
   logic [ID_W-1:0]   ev_id_q, ev_id_d;
   logic [ID_W-1:0]   last_grant_q, last_grant_d;
   logic [N-1:0]      pending_q, pending_d;
   logic [N-1:0]      clr_mask;
   logic              load;
   int                win_idx;
   int                best_dist;
   int                dist_i;
   logic [ID_W-1:0]   win_id;

   // Distance of each pending bit from last_grant+1 (mod N); the smallest
   // distance wins, which is the first set bit in round-robin order.
   always_comb begin
      win_idx   = 0;
      best_dist = N;
      dist_i    = 0;
      for (int i = 0; i < N; i++) begin
         dist_i = (i + 2 * N - 1 - int'(last_grant_q)) % N;
         if (pending_q[i] && (dist_i < best_dist)) begin
            best_dist = dist_i;
            win_idx   = i;
         end
      end
   end

   assign win_id = ID_W'(win_idx);

   always_comb begin
      state_d      = state_q;
      ev_valid_d   = ev_valid_q;
      ev_id_d      = ev_id_q;
      last_grant_d = last_grant_q;
      load         = 1'b0;

      case (state_q)
         S_IDLE: begin
            ev_valid_d = 1'b0;
            if (|pending_q) begin
               load       = 1'b1;
               state_d    = S_PRESENT;
               ev_valid_d = 1'b1;
            end
         end
         S_PRESENT: begin
            ev_valid_d = 1'b1;
            if (ev_ready) begin
               if (|pending_q) begin
                  load = 1'b1;
               end else begin
                  state_d    = S_IDLE;
                  ev_valid_d = 1'b0;
               end
            end
         end
         default: begin
            state_d    = S_IDLE;
            ev_valid_d = 1'b0;
         end
      endcase

      if (load) begin
         ev_id_d      = win_id;
         last_grant_d = win_id;
      end
   end

   // A pulse on the same edge its bit is granted lands as a fresh event.
   always_comb begin
      clr_mask = '0;
      for (int i = 0; i < N; i++) begin
         clr_mask[i] = load && (win_idx == i);
      end
      pending_d = (pending_q & ~clr_mask) | pulse_in;
   end

`ifdef BTN_ARB_DROP_CNT_EN
   logic [N-1:0] drop_vec;
   logic [7:0]   drop_cnt_q, drop_cnt_d;
   int           drop_n;
   int           drop_sum;

   always_comb begin
      drop_vec = pulse_in & pending_q & ~clr_mask;
      drop_n   = 0;
      for (int i = 0; i < N; i++) begin
         drop_n = drop_n + int'(drop_vec[i]);
      end
      drop_sum   = int'(drop_cnt_q) + drop_n;
      drop_cnt_d = (drop_sum > 255) ? 8'd255 : drop_sum[7:0];
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         drop_cnt_q <= 8'd0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign drop_cnt = drop_cnt_q;
`endif

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q      <= S_IDLE;
         ev_valid_q   <= 1'b0;
         ev_id_q      <= '0;
         last_grant_q <= ID_W'(N - 1);
         pending_q    <= '0;
      end else begin
         state_q      <= state_d;
         ev_valid_q   <= ev_valid_d;
         ev_id_q      <= ev_id_d;
         last_grant_q <= last_grant_d;
         pending_q    <= pending_d;
      end
   end

   assign ev_valid = ev_valid_q;
   assign ev_id    = ev_id_q;
   assign pending  = pending_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
module tb_button_event_arbiter;
   localparam int N    = 4;
   localparam int ID_W = 2;

   logic            clk = 1'b0;
   logic            rstb = 1'b1;
   logic [N-1:0]    pulse_in = '0;
   logic            ev_ready = 1'b0;
   logic            ev_valid;
   logic [ID_W-1:0] ev_id;
   logic [N-1:0]    pending;
`ifdef BTN_ARB_DROP_CNT_EN
   logic [7:0]      drop_cnt;
`endif

   int errors = 0;
   int checks = 0;

   button_event_arbiter #(.N(N), .ID_W(ID_W)) dut (
      .clk      (clk),
      .rstb     (rstb),
      .pulse_in (pulse_in),
      .ev_valid (ev_valid),
      .ev_id    (ev_id),
      .ev_ready (ev_ready),
      .pending  (pending)
`ifdef BTN_ARB_DROP_CNT_EN
      ,
      .drop_cnt (drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: the set of waiting buttons, the event on offer and
   // the drop tally, advanced once per rising edge from the rules.
   typedef struct packed {
      logic            valid;
      logic [ID_W-1:0] id;
      logic [ID_W-1:0] last;
      logic [N-1:0]    pend;
      logic [7:0]      drops;
   } mstate_t;

   localparam mstate_t M_RESET = '{valid: 1'b0, id: '0, last: ID_W'(N - 1),
                                   pend: '0, drops: 8'd0};

   mstate_t m = M_RESET;

   function automatic mstate_t model_next(mstate_t s, logic [N-1:0] p, logic r);
      mstate_t n;
      int      w;
      int      idx;
      n = s;
      w = -1;
      idx = 0;
      if (!s.valid || r) begin
         for (int k = 1; k <= N; k++) begin
            idx = (int'(s.last) + k) % N;
            if (w < 0 && s.pend[idx]) w = idx;
         end
         if (w >= 0) begin
            n.valid   = 1'b1;
            n.id      = ID_W'(w);
            n.last    = ID_W'(w);
            n.pend[w] = 1'b0;
         end else begin
            n.valid = 1'b0;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (p[i]) begin
            if (n.pend[i]) begin
               if (n.drops != 8'd255) n.drops = n.drops + 8'd1;
            end else begin
               n.pend[i] = 1'b1;
            end
         end
      end
      return n;
   endfunction

   always @(posedge clk or negedge rstb) begin
      if (!rstb) m <= M_RESET;
      else       m <= model_next(m, pulse_in, ev_ready);
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("model ev_valid", 32'(ev_valid), 32'(m.valid));
      chk("model ev_id",    32'(ev_id),    32'(m.id));
      chk("model pending",  32'(pending),  32'(m.pend));
`ifdef BTN_ARB_DROP_CNT_EN
      chk("model drop_cnt", 32'(drop_cnt), 32'(m.drops));
`endif
   end

   task automatic drive(input logic [N-1:0] p, input logic r);
      @(negedge clk);
      pulse_in = p;
      ev_ready = r;
   endtask

   task automatic do_reset();
      @(negedge clk);
      pulse_in = '0;
      ev_ready = 1'b0;
      #2 rstb = 1'b0;
      @(negedge clk);
      rstb = 1'b1;
   endtask

   task automatic chk_drop(input string name, input int exp);
`ifdef BTN_ARB_DROP_CNT_EN
      chk(name, 32'(drop_cnt), 32'(exp));
`endif
   endtask

   logic [4:0] vec [16] = '{5'b1_0101, 5'b0_0011, 5'b0_0011, 5'b1_1000,
                            5'b1_0000, 5'b0_1111, 5'b0_1111, 5'b1_0110,
                            5'b1_1001, 5'b0_0000, 5'b1_0010, 5'b1_0100,
                            5'b0_1000, 5'b1_1000, 5'b1_0000, 5'b1_0000};

   initial begin
      #1 rstb = 1'b0;
      #3 rstb = 1'b1;
      @(negedge clk);
      chk("reset ev_valid", 32'(ev_valid), 32'd0);
      chk("reset ev_id",    32'(ev_id),    32'd0);
      chk("reset pending",  32'(pending),  32'd0);
      chk_drop("reset drop_cnt", 0);

      // single press, 2-cycle latency, one-cycle event
      drive(4'b0100, 1'b1);
      drive(4'b0000, 1'b1);
      chk("single pending set", 32'(pending), 32'b0100);
      chk("single not yet valid", 32'(ev_valid), 32'd0);
      drive(4'b0000, 1'b1);
      chk("single valid", 32'(ev_valid), 32'd1);
      chk("single id", 32'(ev_id), 32'd2);
      chk("single pending clear", 32'(pending), 32'd0);
      drive(4'b0000, 1'b1);
      chk("single one cycle", 32'(ev_valid), 32'd0);

      // all four at once -> 0,1,2,3 back-to-back
      do_reset();
      drive(4'b1111, 1'b1);
      drive(4'b0000, 1'b1);
      for (int k = 0; k < 4; k++) begin
         drive(4'b0000, 1'b1);
         chk("burst valid", 32'(ev_valid), 32'd1);
         chk("burst id", 32'(ev_id), 32'(k));
      end
      drive(4'b0000, 1'b1);
      chk("burst end", 32'(ev_valid), 32'd0);

      // stalled consumer, repeat presses on the held button
      do_reset();
      drive(4'b0010, 1'b0);
      drive(4'b0000, 1'b0);
      drive(4'b0010, 1'b0);
      chk("stall id", 32'(ev_id), 32'd1);
      chk("stall pending clear", 32'(pending), 32'd0);
      drive(4'b0010, 1'b0);
      chk("stall re-press sets", 32'(pending), 32'b0010);
      chk_drop("stall no drop yet", 0);
      drive(4'b0000, 1'b0);
      chk("stall id held", 32'(ev_id), 32'd1);
      chk("stall pending kept", 32'(pending), 32'b0010);
      chk_drop("stall one drop", 1);
      drive(4'b0000, 1'b1);
      drive(4'b0000, 1'b1);
      chk("stall second id1 valid", 32'(ev_valid), 32'd1);
      chk("stall second id1", 32'(ev_id), 32'd1);
      drive(4'b0000, 1'b1);
      chk("stall drained", 32'(ev_valid), 32'd0);

      // round-robin fairness after granting 3
      do_reset();
      drive(4'b1000, 1'b0);
      drive(4'b0000, 1'b0);
      drive(4'b1001, 1'b0);
      chk("rr first id3", 32'(ev_id), 32'd3);
      drive(4'b0000, 1'b1);
      chk("rr pending 1001", 32'(pending), 32'b1001);
      drive(4'b0000, 1'b1);
      chk("rr wraps to 0", 32'(ev_id), 32'd0);
      drive(4'b0000, 1'b1);
      chk("rr then 3", 32'(ev_id), 32'd3);
      chk("rr then 3 valid", 32'(ev_valid), 32'd1);
      drive(4'b0000, 1'b1);
      chk("rr done", 32'(ev_valid), 32'd0);

      // press landing on the grant edge of the same button
      do_reset();
      drive(4'b0100, 1'b0);
      drive(4'b0100, 1'b0);
      drive(4'b0000, 1'b0);
      chk("same-edge id", 32'(ev_id), 32'd2);
      chk("same-edge pending", 32'(pending), 32'b0100);
      chk_drop("same-edge no drop", 0);
      drive(4'b0000, 1'b1);
      drive(4'b0000, 1'b1);
      chk("same-edge redeliver", 32'(ev_id), 32'd2);
      chk("same-edge redeliver valid", 32'(ev_valid), 32'd1);

      // asynchronous reset while presenting with more pending
      do_reset();
      drive(4'b0110, 1'b0);
      drive(4'b0000, 1'b0);
      drive(4'b0000, 1'b0);
      chk("pre-reset valid", 32'(ev_valid), 32'd1);
      chk("pre-reset pending", 32'(pending), 32'b0100);
      #2 rstb = 1'b0;
      #1;
      chk("async rst ev_valid", 32'(ev_valid), 32'd0);
      chk("async rst ev_id", 32'(ev_id), 32'd0);
      chk("async rst pending", 32'(pending), 32'd0);
      @(negedge clk);
      rstb = 1'b1;
      drive(4'b1001, 1'b1);
      drive(4'b0000, 1'b1);
      drive(4'b0000, 1'b1);
      chk("post-reset starts at 0", 32'(ev_id), 32'd0);

      // mixed directed vectors, checked by the model only
      do_reset();
      for (int v = 0; v < 16; v++) begin
         drive(vec[v][3:0], vec[v][4]);
      end
      for (int v = 0; v < 6; v++) drive(4'b0000, 1'b1);

      // enough repeated presses under a stall to saturate the counter
      drive(4'b1111, 1'b0);
      for (int v = 0; v < 70; v++) drive(4'b1111, 1'b0);
      drive(4'b0000, 1'b0);
      chk_drop("drop saturates", 255);
      for (int v = 0; v < 6; v++) drive(4'b0000, 1'b1);

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1);
   end

endmodule
